pipe_stage_reg: RTL

Parametrised elastic pipeline-stage register that replaces the fixed, always-writing inter-stage registers (fetch/decode, decode/execute, …) in the pipelined datapath. It carries a control bundle and a data bundle between stages with a valid/ready handshake. A two-entry skid buffer lets upstream ready be driven from a flop rather than combinationally from downstream stall. A flush input squashes in-flight entries, and the stage emits a bubble control word whenever it is empty.

---
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Elastic pipeline-stage register with a two-entry skid buffer. It carries a
//   control bundle and a data bundle between pipeline stages under a
//   valid/ready handshake and shows a bubble control word whenever it is empty.
//
// Handshake: an entry moves across a port on a rising clock edge exactly when
// valid and ready are both high in the cycle before that edge. A producer that
// has raised valid keeps its payload stable until the entry is taken. Ready
// may be high with valid low. On the input side, InReady comes only from a
// flop. It is high whenever the skid register is free, so upstream never sees
// a combinational path from the downstream stall.
//
// Ports:
//   Clk        in   clock, every state update happens on the rising edge
//   Rst        in   asynchronous reset, active low
//   InValid    in   upstream presents an entry
//   InReady    out  stage can accept an entry (registered, skid is empty)
//   InCtrl     in   upstream control bundle [CTRL_W]
//   InData     in   upstream data bundle [DATA_W]
//   OutValid   out  OutCtrl/OutData hold a valid entry
//   OutReady   in   downstream accepts the head entry (~Stall)
//   OutCtrl    out  head control, or BUBBLE_CTRL when empty
//   OutData    out  head data, or zero when empty
//   Flush      in   squash every entry held in the stage
//   Occupancy  out  number of valid entries, 0..2
module pipe_stage_reg #(
    parameter int                CTRL_W      = 12,
    parameter int                DATA_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    input  logic              Flush,
    output logic [1:0]        Occupancy
);

    // The state encoding equals the number of entries held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        occupancy_q, occupancy_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = InValid & in_ready_q;
    assign out_fire = out_valid_q & OutReady;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_ctrl_d = InCtrl;
                    main_data_d = InData;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_ctrl_d = InCtrl;
                    main_data_d = InData;
                end else if (in_fire) begin
                    state_d     = ST_TWO;
                    skid_ctrl_d = InCtrl;
                    skid_data_d = InData;
                end else if (out_fire) begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = BUBBLE_CTRL;
                    main_data_d = '0;
                end
            end
            ST_TWO: begin
                // InReady is low here, so only the output side can move.
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_ctrl_d = BUBBLE_CTRL;
                    skid_data_d = '0;
                end
            end
            default: begin
                // The unused encoding recovers to a clean empty stage.
                state_d     = ST_EMPTY;
                main_ctrl_d = BUBBLE_CTRL;
                main_data_d = '0;
                skid_ctrl_d = BUBBLE_CTRL;
                skid_data_d = '0;
            end
        endcase

        // Flush overrides every other event. An entry offered in the same
        // cycle is dropped. A head consumed downstream in this cycle has
        // already been delivered.
        if (Flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = BUBBLE_CTRL;
            main_data_d = '0;
            skid_ctrl_d = BUBBLE_CTRL;
            skid_data_d = '0;
        end

        // The status outputs are registered copies of the next state, so
        // every output comes straight from a flop.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
        occupancy_d = state_d;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= BUBBLE_CTRL;
            main_data_q <= '0;
            skid_ctrl_q <= BUBBLE_CTRL;
            skid_data_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign InReady   = in_ready_q;
    assign OutValid  = out_valid_q;
    assign OutCtrl   = main_ctrl_q;
    assign OutData   = main_data_q;
    assign Occupancy = occupancy_q;

endmodule
